// File: rtl/writeback_regfile.sv
// writeback_regfile
// Write-back stage of the Y86-64 SEQ processor together with the
// architectural register file it owns.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   wb_valid            an instruction is presented for commit this cycle
//   icode, rA, rB, cnd  decoded fields and condition flag of that instruction
//   valE, valM          ALU result and memory read data to be committed
//   stat_in             status of the instruction (AOK/HLT/ADR/INS)
//   rax .. r14          current register contents, indices 0..14
//   stat_out            processor status, same encoding as stat_in
//   halted              high once the processor has stopped
//   retired             count of committed instructions (wraps)
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [1:0]       stat_in,
    output logic [63:0]      rax,
    output logic [63:0]      rcx,
    output logic [63:0]      rdx,
    output logic [63:0]      rbx,
    output logic [63:0]      rsp,
    output logic [63:0]      rbp,
    output logic [63:0]      rsi,
    output logic [63:0]      rdi,
    output logic [63:0]      r8,
    output logic [63:0]      r9,
    output logic [63:0]      r10,
    output logic [63:0]      r11,
    output logic [63:0]      r12,
    output logic [63:0]      r13,
    output logic [63:0]      r14,
    output logic [1:0]       stat_out,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_INS = 2'd3;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state;
    logic [63:0] regs [0:14];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;

    // Destination selection; a conditional move that fails its condition
    // behaves as if it had no destination at all.
    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            4'h2:                      dst_e = cnd ? rB : REG_NONE;
            4'h3, 4'h6:                dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e = REG_RSP;
            default:                   dst_e = REG_NONE;
        endcase
        case (icode)
            4'h5, 4'hB: dst_m = rA;
            default:    dst_m = REG_NONE;
        endcase
    end

    // Commit and status tracking. The valM write comes second so that it
    // wins when both destinations name the same register (popq %rsp).
    // Any non-AOK outcome stops the machine without touching registers,
    // and only HLT-type stops count as a retired instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end
            state    <= RUN;
            stat_out <= STAT_AOK;
            halted   <= 1'b0;
            retired  <= '0;
        end else if (state == RUN && wb_valid) begin
            if (stat_in == STAT_HLT || (stat_in == STAT_AOK && icode == 4'h0)) begin
                retired  <= retired + CNT_W'(1);
                state    <= HALTED;
                stat_out <= STAT_HLT;
                halted   <= 1'b1;
            end else if (stat_in == STAT_AOK && icode <= 4'hB) begin
                if (dst_e != REG_NONE) begin
                    regs[dst_e] <= valE;
                end
                if (dst_m != REG_NONE) begin
                    regs[dst_m] <= valM;
                end
                retired <= retired + CNT_W'(1);
            end else if (stat_in == STAT_AOK) begin
                state    <= HALTED;
                stat_out <= STAT_INS;
                halted   <= 1'b1;
            end else begin
                state    <= HALTED;
                stat_out <= stat_in;
                halted   <= 1'b1;
            end
        end
    end

    assign rax = regs[0];
    assign rcx = regs[1];
    assign rdx = regs[2];
    assign rbx = regs[3];
    assign rsp = regs[4];
    assign rbp = regs[5];
    assign rsi = regs[6];
    assign rdi = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile: a table of directed single-cycle vectors
// followed by a hand-written sequence covering the absence of write-through.
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [1:0]  stat_in;
    logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
    logic [63:0] r8, r9, r10, r11, r12, r13, r14;
    logic [1:0]  stat_out;
    logic        halted;
    logic [63:0] retired;

    int checks_total;
    int checks_passed;

    writeback_regfile #(
        .RSP_INIT(64'h200),
        .CNT_W(64)
    ) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .icode(icode),
        .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
        .stat_in(stat_in),
        .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
        .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
        .r12(r12), .r13(r13), .r14(r14),
        .stat_out(stat_out), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock edge of stimulus plus the state expected after it.
    typedef struct {
        logic        rst;
        logic        wbv;
        logic [3:0]  ic;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cn;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [1:0]  st;
        logic [3:0]  idx_a;
        logic [63:0] exp_a;
        logic [3:0]  idx_b;
        logic [63:0] exp_b;
        logic [1:0]  exp_stat;
        logic        exp_halt;
        logic [63:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] get_reg(input logic [3:0] idx);
        case (idx)
            4'd0:    return rax;
            4'd1:    return rcx;
            4'd2:    return rdx;
            4'd3:    return rbx;
            4'd4:    return rsp;
            4'd5:    return rbp;
            4'd6:    return rsi;
            4'd7:    return rdi;
            4'd8:    return r8;
            4'd9:    return r9;
            4'd10:   return r10;
            4'd11:   return r11;
            4'd12:   return r12;
            4'd13:   return r13;
            default: return r14;
        endcase
    endfunction

    task automatic check_val(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one row's inputs away from the active edge, then let one edge pass.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        wb_valid = v.wbv;
        icode    = v.ic;
        rA       = v.ra;
        rB       = v.rb;
        cnd      = v.cn;
        valE     = v.ve;
        valM     = v.vm;
        stat_in  = v.st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int row, input vec_t v);
        check_val($sformatf("row%0d_reg%0d", row, v.idx_a), get_reg(v.idx_a), v.exp_a);
        check_val($sformatf("row%0d_reg%0d", row, v.idx_b), get_reg(v.idx_b), v.exp_b);
        check_val($sformatf("row%0d_stat", row), {62'h0, stat_out}, {62'h0, v.exp_stat});
        check_val($sformatf("row%0d_halted", row), {63'h0, halted}, {63'h0, v.exp_halt});
        check_val($sformatf("row%0d_retired", row), retired, v.exp_ret);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset    = 1'b1;
        wb_valid = 1'b0;
        icode    = 4'h0;
        rA       = 4'hF;
        rB       = 4'hF;
        cnd      = 1'b0;
        valE     = 64'h0;
        valM     = 64'h0;
        stat_in  = 2'd0;

        //            rst wbv ic    ra    rb    cn  valE        valM        st    ia    expA        ib    expB        stat  hlt ret
        vecs.push_back('{1, 0, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd4, 64'h200,    4'd0, 64'h0,      2'd0, 0, 64'd0});
        vecs.push_back('{0, 1, 4'h3, 4'hF, 4'h2, 0, 64'h1234,   64'h0,      2'd0, 4'd2, 64'h1234,   4'd4, 64'h200,    2'd0, 0, 64'd1});
        vecs.push_back('{0, 1, 4'h2, 4'hF, 4'h3, 0, 64'h5,      64'h0,      2'd0, 4'd3, 64'h0,      4'd2, 64'h1234,   2'd0, 0, 64'd2});
        vecs.push_back('{0, 1, 4'hB, 4'h0, 4'hF, 0, 64'h208,    64'hDEAD,   2'd0, 4'd0, 64'hDEAD,   4'd4, 64'h208,    2'd0, 0, 64'd3});
        vecs.push_back('{0, 1, 4'hB, 4'h4, 4'hF, 0, 64'h210,    64'h77,     2'd0, 4'd4, 64'h77,     4'd0, 64'hDEAD,   2'd0, 0, 64'd4});
        vecs.push_back('{0, 0, 4'h3, 4'hF, 4'h2, 0, 64'h9999,   64'h0,      2'd0, 4'd2, 64'h1234,   4'd4, 64'h77,     2'd0, 0, 64'd4});
        vecs.push_back('{0, 1, 4'h6, 4'h1, 4'h5, 0, 64'hABC,    64'h0,      2'd0, 4'd5, 64'hABC,    4'd1, 64'h0,      2'd0, 0, 64'd5});
        vecs.push_back('{0, 1, 4'h2, 4'h0, 4'h6, 1, 64'h55,     64'h0,      2'd0, 4'd6, 64'h55,     4'd0, 64'hDEAD,   2'd0, 0, 64'd6});
        vecs.push_back('{0, 1, 4'h8, 4'hF, 4'hF, 0, 64'h1F8,    64'h0,      2'd0, 4'd4, 64'h1F8,    4'd14, 64'h0,     2'd0, 0, 64'd7});
        vecs.push_back('{0, 1, 4'h5, 4'h1, 4'hF, 0, 64'h0,      64'h9,      2'd2, 4'd1, 64'h0,      4'd4, 64'h1F8,    2'd2, 1, 64'd7});
        vecs.push_back('{0, 1, 4'h3, 4'hF, 4'h1, 0, 64'h3,      64'h0,      2'd0, 4'd1, 64'h0,      4'd2, 64'h1234,   2'd2, 1, 64'd7});
        vecs.push_back('{1, 0, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd4, 64'h200,    4'd2, 64'h0,      2'd0, 0, 64'd0});
        vecs.push_back('{0, 1, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd0, 64'h0,      4'd4, 64'h200,    2'd1, 1, 64'd1});
        vecs.push_back('{1, 1, 4'h3, 4'hF, 4'h0, 0, 64'h7,      64'h0,      2'd0, 4'd0, 64'h0,      4'd4, 64'h200,    2'd0, 0, 64'd0});
        vecs.push_back('{0, 1, 4'hD, 4'hF, 4'h0, 0, 64'h7,      64'h0,      2'd0, 4'd0, 64'h0,      4'd4, 64'h200,    2'd3, 1, 64'd0});
        vecs.push_back('{1, 0, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd4, 64'h200,    4'd0, 64'h0,      2'd0, 0, 64'd0});
        vecs.push_back('{0, 1, 4'h3, 4'hF, 4'h7, 0, 64'h1,      64'h0,      2'd1, 4'd7, 64'h0,      4'd4, 64'h200,    2'd1, 1, 64'd1});
        vecs.push_back('{1, 0, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd7, 64'h0,      4'd4, 64'h200,    2'd0, 0, 64'd0});
        vecs.push_back('{0, 1, 4'h5, 4'h8, 4'hF, 0, 64'h0,      64'h88,     2'd0, 4'd8, 64'h88,     4'd4, 64'h200,    2'd0, 0, 64'd1});
        vecs.push_back('{0, 1, 4'h1, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd8, 64'h88,     4'd14, 64'h0,     2'd0, 0, 64'd2});
        vecs.push_back('{0, 1, 4'h3, 4'hF, 4'h9, 0, 64'h5,      64'h0,      2'd3, 4'd9, 64'h0,      4'd8, 64'h88,     2'd3, 1, 64'd2});
        vecs.push_back('{1, 0, 4'h0, 4'hF, 4'hF, 0, 64'h0,      64'h0,      2'd0, 4'd8, 64'h0,      4'd4, 64'h200,    2'd0, 0, 64'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // A committed value must not appear before its commit edge, then
        // must appear right after it.
        @(negedge clk);
        reset    = 1'b0;
        wb_valid = 1'b1;
        icode    = 4'h3;
        rA       = 4'hF;
        rB       = 4'h9;
        cnd      = 1'b0;
        valE     = 64'h42;
        valM     = 64'h0;
        stat_in  = 2'd0;
        #1;
        check_val("no_bypass_r9", r9, 64'h0);
        @(posedge clk);
        #1;
        check_val("commit_r9", r9, 64'h42);
        check_val("commit_retired", retired, 64'd1);
        @(negedge clk);
        wb_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_r9", r9, 64'h42);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
